// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display fetch path and two
// round-robin, burst-limited clients that are served only during blanking.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  px_clk,
  input  logic                  reset,
  input  logic                  activevideo,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_rvalid,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] cl_rdata,
  output logic [15:0]           deny_cnt
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DISP} state_t;
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);
  state_t state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic rr_q, rr_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic disp_prev_q, disp_prev_d;
  logic [DATA_WIDTH-1:0] disp_hold_q, disp_hold_d;
  logic [15:0] deny_q, deny_d;
  logic own, own_req, oth_req, keep, gnt, sel, g0, g1;
  always_comb begin
    own = state_q == OWN1;
    own_req = own ? c1_req : c0_req;
    oth_req = own ? c0_req : c1_req;
    keep = own_req && (burst_q < MAX_B || !oth_req);
    state_d = state_q;
    burst_d = burst_q;
    rr_d = rr_q;
    gnt = 1'b0;
    sel = 1'b0;
    if (activevideo) begin
      state_d = DISP;
      burst_d = '0;
    end else begin
      if (state_q == OWN0 || state_q == OWN1) begin
        gnt = keep || oth_req;
        sel = keep ? own : !own;
        burst_d = !gnt ? '0 : keep ? (burst_q == MAX_B ? burst_q : burst_q + 8'd1) : 8'd1;
      end else begin
        // rr_q=1 means c1 was served last, so c0 wins a tie
        gnt = c0_req || c1_req;
        sel = c1_req && (!c0_req || !rr_q);
        burst_d = gnt ? 8'd1 : '0;
      end
      state_d = !gnt ? IDLE : sel ? OWN1 : OWN0;
      rr_d = gnt ? sel : rr_q;
    end
    g0 = gnt && !sel;
    g1 = gnt && sel;
    rvalid_d = {g1 && !c1_we, g0 && !c0_we};
    deny_d = ((c0_req || c1_req) && !gnt && deny_q != 16'hFFFF) ? deny_q + 16'd1 : deny_q;
    disp_prev_d = activevideo;
    disp_hold_d = disp_prev_q ? mem_rdata : disp_hold_q;
  end
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      rr_q <= 1'b1;
      rvalid_q <= '0;
      disp_prev_q <= 1'b0;
      disp_hold_q <= '0;
      deny_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      rr_q <= rr_d;
      rvalid_q <= rvalid_d;
      disp_prev_q <= disp_prev_d;
      disp_hold_q <= disp_hold_d;
      deny_q <= deny_d;
    end
  end
  assign c0_gnt = g0;
  assign c1_gnt = g1;
  assign mem_addr = g0 ? c0_addr : g1 ? c1_addr : disp_addr;
  assign mem_we = (g0 && c0_we) || (g1 && c1_we);
  assign mem_wdata = sel ? c1_wdata : c0_wdata;
  assign c0_rvalid = rvalid_q[0];
  assign c1_rvalid = rvalid_q[1];
  assign cl_rdata = mem_rdata;
  assign disp_rdata = disp_prev_q ? mem_rdata : disp_hold_q;
  assign deny_cnt = deny_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scenario tasks plus randomized traffic against a behavioural
// ownership/burst model and a shadow copy of the VRAM contents.
module tb_vram_arbiter;
  localparam int AW = 15, DW = 8, MB = 16, DEPTH = 1 << AW;
  logic px_clk = 1'b0;
  logic reset, activevideo, mem_we;
  logic [AW-1:0] disp_addr, mem_addr, c0_addr, c1_addr;
  logic [DW-1:0] disp_rdata, mem_wdata, mem_rdata, c0_wdata, c1_wdata, cl_rdata;
  logic c0_req, c0_we, c0_gnt, c0_rvalid, c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [15:0] deny_cnt;
  logic [DW-1:0] vram [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  int n_checks = 0, n_fail = 0;
  int m_owner, m_streak, m_last, m_deny;
  bit m_rv0, m_rv1, m_disp_prev;
  logic [DW-1:0] m_rdata, m_disp_data, m_disp_hold;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .px_clk(px_clk), .reset(reset), .activevideo(activevideo), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c1_req(c1_req),
    .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_gnt(c1_gnt),
    .c1_rvalid(c1_rvalid), .cl_rdata(cl_rdata), .deny_cnt(deny_cnt)
  );

  always #5 px_clk = ~px_clk;

  function automatic logic [DW-1:0] init_byte(int a);
    return a == 'h0123 ? 8'h5A : DW'(a * 7 + (a >> 8));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) vram[i] = init_byte(i);
    forever begin
      @(posedge px_clk);
      mem_rdata <= vram[mem_addr];
      if (mem_we) vram[mem_addr] = mem_wdata;
    end
  end

  function automatic bit req_of(int n);
    return n == 0 ? c0_req : c1_req;
  endfunction

  // Which client the rules say gets the port this cycle (-1 = none)
  function automatic int pick();
    int o;
    if (activevideo) return -1;
    if (m_owner >= 0) begin
      o = 1 - m_owner;
      if (req_of(m_owner) && (m_streak < MB || !req_of(o))) return m_owner;
      return req_of(o) ? o : -1;
    end
    if (c0_req && c1_req) return 1 - m_last;
    if (c0_req) return 0;
    if (c1_req) return 1;
    return -1;
  endfunction

  function automatic logic [AW-1:0] exp_addr(int g);
    return g == 0 ? c0_addr : g == 1 ? c1_addr : disp_addr;
  endfunction

  function automatic bit exp_we(int g);
    return g == 0 ? c0_we : g == 1 ? c1_we : 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_disp();
    return m_disp_prev ? m_disp_data : m_disp_hold;
  endfunction

  task automatic step();
    int g;
    logic [AW-1:0] a;
    g = pick();
    a = exp_addr(g);
    if (m_disp_prev) m_disp_hold = m_disp_data;
    m_disp_data = shadow[disp_addr];
    m_rv0 = g == 0 && !c0_we && !reset;
    m_rv1 = g == 1 && !c1_we && !reset;
    m_rdata = shadow[a];
    if (exp_we(g)) shadow[a] = g == 0 ? c0_wdata : c1_wdata;
    m_disp_prev = activevideo && !reset;
    if (reset) begin
      m_owner = -1; m_streak = 0; m_last = 1; m_deny = 0; m_disp_hold = '0;
    end else begin
      if ((c0_req || c1_req) && g < 0 && m_deny < 65535) m_deny++;
      if (g < 0) begin
        m_owner = -1; m_streak = 0;
      end else begin
        m_streak = (g == m_owner) ? (m_streak < MB ? m_streak + 1 : MB) : 1;
        m_owner = g; m_last = g;
      end
    end
    @(posedge px_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; c0_req = 1; c0_we = 0; c0_addr = 15'h0005;
    #2;
    step();
    c0_req = 0;
    #2;
    n_checks++;
    if (c0_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_read_rvalid: got %b expected 0", c0_rvalid); end
    reset = 0;
    step();
    #2;
    n_checks++;
    if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, mem_we});
    end
    n_checks++;
    if (deny_cnt !== 16'd0 || disp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_counters: deny %0d disp %h expected 0 00", deny_cnt, disp_rdata);
    end
  endtask

  task automatic test_display();
    int bad = 0;
    activevideo = 1; c0_req = 1; c0_we = 0; c0_addr = 15'h0100;
    for (int i = 0; i < 100; i++) begin
      disp_addr = AW'($urandom);
      #2;
      if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== disp_addr) bad++;
      if (i > 0 && disp_rdata !== exp_disp()) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL display_owns_port: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (deny_cnt !== 16'd100) begin n_fail++; $display("FAIL display_deny: got %0d expected 100", deny_cnt); end
  endtask

  task automatic test_single_read();
    activevideo = 0; c0_req = 0; c1_req = 1; c1_we = 0; c1_addr = 15'h0123;
    #2;
    n_checks++;
    if (c1_gnt !== 1'b1 || c0_gnt !== 1'b0 || mem_addr !== 15'h0123 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL c1_read_grant: gnt %b%b addr %h we %b expected 10 0123 0", c1_gnt, c0_gnt, mem_addr, mem_we);
    end
    n_checks++;
    if (disp_rdata !== exp_disp()) begin n_fail++; $display("FAIL disp_after_blank: got %h expected %h", disp_rdata, exp_disp()); end
    step();
    c1_req = 0;
    #2;
    n_checks++;
    if (c1_rvalid !== 1'b1 || c0_rvalid !== 1'b0 || cl_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL c1_read_data: rvalid %b data %h expected 1 5a", c1_rvalid, cl_rdata);
    end
    step();
  endtask

  task automatic test_alternate();
    int bad = 0, deny0;
    deny0 = m_deny;
    c0_req = 1; c1_req = 1; c0_we = 0; c1_we = 0;
    for (int k = 0; k < 64; k++) begin
      c0_addr = AW'($urandom); c1_addr = AW'($urandom);
      #2;
      if (c1_gnt !== 1'((k / MB) % 2) || c0_gnt !== 1'(1 - (k / MB) % 2)) bad++;
      if ({c1_rvalid, c0_rvalid} !== {m_rv1, m_rv0} || ((m_rv0 || m_rv1) && cl_rdata !== m_rdata)) bad++;
      step();
    end
    c0_req = 0; c1_req = 0;
    #2;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL burst_alternation: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (deny_cnt !== 16'(deny0)) begin n_fail++; $display("FAIL burst_deny: got %0d expected %0d", deny_cnt, deny0); end
    step();
  endtask

  task automatic test_preempt();
    int bad = 0, cnt = 1, got = 0;
    c0_req = 1; c0_we = 1;
    for (int k = 0; k < 4; k++) begin
      c0_addr = AW'($urandom); c0_wdata = DW'($urandom);
      #2;
      if (c0_gnt !== 1'b1) bad++;
      step();
    end
    activevideo = 1; disp_addr = AW'($urandom);
    #2;
    n_checks++;
    if (bad != 0 || c0_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== disp_addr) begin
      n_fail++; $display("FAIL preempt: bad %0d gnt %b we %b addr %h expected 0 0 0 %h", bad, c0_gnt, mem_we, mem_addr, disp_addr);
    end
    step(); step(); step();
    activevideo = 0;
    #2;
    n_checks++;
    if (c0_gnt !== 1'b1) begin n_fail++; $display("FAIL preempt_resume: got %b expected 1", c0_gnt); end
    step();
    c1_req = 1; c1_we = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (c1_gnt) begin got = 1; break; end
      if (c0_gnt) cnt++;
      step();
    end
    n_checks++;
    if (got != 1 || cnt != MB) begin n_fail++; $display("FAIL preempt_burst_restart: got %0d c0 grants (handover %0d) expected %0d", cnt, got, MB); end
    c0_req = 0; c1_req = 0;
    step();
  endtask

  task automatic test_write_readback();
    c0_req = 1; c0_we = 1; c0_addr = 15'h7FFF; c0_wdata = 8'hA5;
    #2;
    n_checks++;
    if (c0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h7FFF || mem_wdata !== 8'hA5) begin
      n_fail++; $display("FAIL c0_write: gnt %b we %b addr %h data %h expected 1 1 7fff a5", c0_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    c0_req = 0; activevideo = 1; disp_addr = 15'h7FFF;
    step();
    activevideo = 0; disp_addr = 15'h0000;
    #2;
    n_checks++;
    if (disp_rdata !== 8'hA5) begin n_fail++; $display("FAIL disp_readback: got %h expected a5", disp_rdata); end
    step(); step();
    n_checks++;
    if (disp_rdata !== 8'hA5) begin n_fail++; $display("FAIL disp_hold: got %h expected a5", disp_rdata); end
  endtask

  task automatic test_random();
    int g = -1, e_gnt = 0, e_mem = 0, e_rd = 0, e_deny = 0, e_disp = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) == 0;
      activevideo = $urandom_range(0, 9) < 3;
      disp_addr = AW'($urandom);
      if (!c0_req || g == 0) begin
        c0_req = $urandom_range(0, 9) < 6; c0_we = 1'($urandom); c0_addr = AW'($urandom); c0_wdata = DW'($urandom);
      end
      if (!c1_req || g == 1) begin
        c1_req = $urandom_range(0, 9) < 6; c1_we = 1'($urandom); c1_addr = AW'($urandom); c1_wdata = DW'($urandom);
      end
      #2;
      g = pick();
      if ({c1_gnt, c0_gnt} !== {g == 1, g == 0}) e_gnt++;
      if (mem_addr !== exp_addr(g) || mem_we !== exp_we(g) || (exp_we(g) && mem_wdata !== (g == 0 ? c0_wdata : c1_wdata))) e_mem++;
      if ({c1_rvalid, c0_rvalid} !== {m_rv1, m_rv0} || ((m_rv0 || m_rv1) && cl_rdata !== m_rdata)) e_rd++;
      if (deny_cnt !== 16'(m_deny)) e_deny++;
      if (disp_rdata !== exp_disp()) e_disp++;
      step();
    end
    reset = 0; activevideo = 0; c0_req = 0; c1_req = 0;
    step();
    n_checks++;
    if (e_gnt != 0) begin n_fail++; $display("FAIL random_gnt: got %0d bad cycles expected 0", e_gnt); end
    n_checks++;
    if (e_mem != 0) begin n_fail++; $display("FAIL random_mem_port: got %0d bad cycles expected 0", e_mem); end
    n_checks++;
    if (e_rd != 0) begin n_fail++; $display("FAIL random_rvalid: got %0d bad cycles expected 0", e_rd); end
    n_checks++;
    if (e_deny != 0) begin n_fail++; $display("FAIL random_deny: got %0d bad cycles expected 0", e_deny); end
    n_checks++;
    if (e_disp != 0) begin n_fail++; $display("FAIL random_disp_rdata: got %0d bad cycles expected 0", e_disp); end
  endtask

  task automatic test_saturate();
    int bad = 0;
    c0_req = 1; c1_req = 1; c0_we = 0; c1_we = 0; activevideo = 1;
    for (int i = 0; i < 70000; i++) begin
      if (c0_gnt || c1_gnt) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL saturate_no_gnt: got %0d grant cycles expected 0", bad); end
    n_checks++;
    if (deny_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL deny_saturate: got %0d expected 65535", deny_cnt); end
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (deny_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL deny_stays_saturated: got %0d expected 65535", deny_cnt); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_byte(i);
    reset = 1; activevideo = 0; disp_addr = '0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    m_owner = -1; m_streak = 0; m_last = 1; m_deny = 0;
    m_rv0 = 0; m_rv1 = 0; m_disp_prev = 0; m_rdata = '0; m_disp_data = '0; m_disp_hold = '0;
    @(posedge px_clk);
    #1;
    test_reset();
    test_display();
    test_single_read();
    test_alternate();
    test_preempt();
    test_write_readback();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the display fetch path and two client requesters: c0, the animation frame updater, and c1, the host/debug writer.
- The display owns the port whenever the sync generator reports activevideo=1.
- Clients are served only during blanking. They are arbitrated round-robin, with bounded bursts.
- Sits between vga_sync_gen (activevideo) plus the pixel pipeline (disp_addr) and the VRAM macro.

Parameters:
- ADDR_WIDTH, 15, VRAM address width
- DATA_WIDTH, 8, VRAM data width
- MAX_BURST, 16, maximum consecutive grants to one client while the other client requests (1..255)

Ports:
- px_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- activevideo  in  1  from vga_sync_gen; 1 = display owns the port this cycle
- disp_addr  in  ADDR_WIDTH  display fetch address
- disp_rdata  out  DATA_WIDTH  display read data, valid the cycle after the fetch
- mem_addr  out  ADDR_WIDTH  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_WIDTH  VRAM write data
- mem_rdata  in  DATA_WIDTH  VRAM read data (1-cycle latency)
- cN_req  in  1  client N request (N=0,1); held high until granted
- cN_we  in  1  client N write (1) / read (0)
- cN_addr  in  ADDR_WIDTH  client N address
- cN_wdata  in  DATA_WIDTH  client N write data
- cN_gnt  out  1  client N access performed this cycle
- cN_rvalid  out  1  client N read data valid on cl_rdata
- cl_rdata  out  DATA_WIDTH  shared client read data
- deny_cnt  out  16  saturating count of cycles in which some client requested and none was granted

Behaviour:
- Reset values:
  - all gnt/rvalid = 0; mem_we = 0; deny_cnt = 0.
  - Owner state = IDLE; burst counter = 0; rr pointer = "c1 last", so c0 wins the first tie.
- States:
  - DISP: activevideo=1.
  - IDLE: blanking, no owner.
  - OWN0 / OWN1: blanking, client owns the port.
- Grant decision is combinational from the registered state and the current inputs. The access is issued in the same cycle.
- DISP (activevideo=1):
  - mem_addr = disp_addr, mem_we = 0, no gnt.
  - Preempts any owner immediately, including mid-burst; the burst counter clears.
  - Next state on activevideo falling = IDLE.
- IDLE:
  - If exactly one client requests, grant it.
  - If both request, grant the one not served last (rr pointer).
  - The granted client goes to OWNn; rr pointer updates to n.
- OWNn:
  - If cn_req=1 and (burst < MAX_BURST or other client idle), grant n again; burst increments, saturating at MAX_BURST.
  - If the other client requests and burst = MAX_BURST, or cn_req=0: hand over to the other client if it requests (burst=1), else go to IDLE (burst=0).
- On a grant:
  - mem_addr = cN_addr, mem_we = cN_we, mem_wdata = cN_wdata.
  - A client read produces cN_rvalid=1 and cl_rdata = mem_rdata exactly one cycle later.
  - rvalid is produced even if activevideo has risen in that cycle: the read already completed.
- No grant cycles:
  - mem_we = 0; mem_addr = disp_addr.
- Display data:
  - disp_rdata = mem_rdata when the previous cycle was DISP (registered flag); otherwise disp_rdata holds its last value.
- Ordering: at most one gnt per cycle; gnt is never asserted while activevideo=1.
- deny_cnt:
  - Increments when (c0_req|c1_req) and no gnt; saturates at 16'hFFFF.
- Reset mid-operation:
  - All grants and rvalid are cancelled the next cycle.
  - A read issued in the reset cycle returns no rvalid.

Test Plan:
- Reset, activevideo=1 for 100 cycles with c0_req=1 held -> c0_gnt never high; mem_addr tracks disp_addr; deny_cnt=100.
- activevideo falls, only c1 read at addr 0x0123 (VRAM holds 0x5A) -> c1_gnt the same cycle; c1_rvalid=1 with cl_rdata=0x5A one cycle later.
- Blanking, c0 and c1 request from the same cycle and hold, MAX_BURST=16 -> 16 c0 grants, 16 c1 grants, alternating with no idle gap; deny_cnt unchanged.
- c0 burst at its 5th grant when activevideo rises -> no gnt that cycle; after the next blank, c0 is still owed service and restarts with burst=1.
- c0 write 0xA5 to 0x7FFF during blanking, then a display fetch of 0x7FFF -> disp_rdata=0xA5 one cycle after the fetch.
- Hold both requests with activevideo=1 for 70000 cycles -> deny_cnt saturates at 65535 and stays there.
